// File: rtl/bru_rs.sv
// bru_rs: branch/jump reservation station; CDB-snooping wakeup, age-matrix oldest-ready select.
// Latency: a dispatch or wakeup becomes issuable one cycle later; issue_pkt_o is combinational from state.
// Backpressure: disp_ready_o drops when full (registered count only); selection holds while issue_ready_i=0.
// Optional: define BRU_RS_PERF_CNT_EN to add saturating full/stall cycle counters.
package bru_rs_pkg;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  typedef struct packed {
    logic [3:0]        op;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [ROB_W-1:0]  rob_tag;
    logic [PREG_W-1:0] rs1_tag;
    logic [PREG_W-1:0] rs2_tag;
  } issue_pkt_t;
endpackage

module bru_rs
  import bru_rs_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  issue_pkt_t                 disp_pkt_i,
  input  logic                       disp_rs1_rdy_i,
  input  logic                       disp_rs2_rdy_i,
  input  logic [WB_PORTS-1:0]        cdb_valid_i,
  input  logic [WB_PORTS*PREG_W-1:0] cdb_tag_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output issue_pkt_t                 issue_pkt_o,
  output logic [CNT_W-1:0]           count_o
`ifdef BRU_RS_PERF_CNT_EN
  ,
  output logic [31:0]                perf_full_cyc_o,
  output logic [31:0]                perf_stall_cyc_o
`endif
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  issue_pkt_t       pkt_q [DEPTH];
  issue_pkt_t       pkt_d [DEPTH];
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] rdy_vec, sel_oh, free_oh;
  logic             free_found;
  logic             disp_fire, iss_fire;

  function automatic logic cdb_hit(input logic [PREG_W-1:0]          tag,
                                   input logic [WB_PORTS-1:0]        vld,
                                   input logic [WB_PORTS*PREG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (vld[k] && (tags[k*PREG_W +: PREG_W] == tag)) cdb_hit = 1'b1;
    end
  endfunction

  // Oldest-ready select from registered state; no same-cycle wake-to-issue
  always_comb begin
    rdy_vec = valid_q & rs1_rdy_q & rs2_rdy_q;
    sel_oh  = rdy_vec;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && rdy_vec[j] && age_q[j][i]) sel_oh[i] = 1'b0;
      end
    end
    issue_pkt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) issue_pkt_o = issue_pkt_o | pkt_q[i];
    end
  end

  // Lowest-index free slot for allocation
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign issue_valid_o = |rdy_vec;
  assign disp_ready_o  = (count_q != CNT_W'(DEPTH));
  assign count_o       = count_q;
  assign disp_fire     = disp_valid_i && disp_ready_o && !flush_i;
  assign iss_fire      = issue_valid_o && issue_ready_i && !flush_i;

  // Next state: wakeup, then allocation, then issue retirement (slots are disjoint)
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    pkt_d     = pkt_q;
    age_d     = age_q;
    count_d   = count_q;
    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_hit(pkt_q[i].rs1_tag, cdb_valid_i, cdb_tag_i)) rs1_rdy_d[i] = 1'b1;
        if (valid_q[i] && cdb_hit(pkt_q[i].rs2_tag, cdb_valid_i, cdb_tag_i)) rs2_rdy_d[i] = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_fire && free_oh[i]) begin
          valid_d[i]   = 1'b1;
          pkt_d[i]     = disp_pkt_i;
          rs1_rdy_d[i] = disp_rs1_rdy_i | cdb_hit(disp_pkt_i.rs1_tag, cdb_valid_i, cdb_tag_i);
          rs2_rdy_d[i] = disp_rs2_rdy_i | cdb_hit(disp_pkt_i.rs2_tag, cdb_valid_i, cdb_tag_i);
          age_d[i]     = '0;
          // every entry already present is older than the newcomer
          for (int j = 0; j < DEPTH; j++) age_d[j][i] = valid_q[j];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_fire && sel_oh[i]) begin
          valid_d[i] = 1'b0;
          age_d[i]   = '0;
          for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
        end
      end
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pkt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      count_q   <= count_d;
      pkt_q     <= pkt_d;
      age_q     <= age_d;
    end
  end

`ifdef BRU_RS_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_stall_q;

  // Saturating occupancy counters; survive flush, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((count_q == CNT_W'(DEPTH)) && (perf_full_q != 32'hFFFF_FFFF))
        perf_full_q <= perf_full_q + 32'd1;
      if ((count_q != '0) && !issue_valid_o && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_full_cyc_o  = perf_full_q;
  assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_bru_rs.sv
// tb_bru_rs: directed and random stimulus for bru_rs against an ordered-queue reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Model: entries kept in dispatch order; the first entry with both sources ready is the one issued.
module tb_bru_rs;
  import bru_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int WB    = 2;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                    clk, rst, flush_i, disp_valid_i, disp_ready_o;
  issue_pkt_t              disp_pkt_i, issue_pkt_o;
  logic                    disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [WB-1:0]           cdb_valid_i;
  logic [WB*PREG_W-1:0]    cdb_tag_i;
  logic                    issue_valid_o, issue_ready_i;
  logic [CNT_W-1:0]        count_o;
`ifdef BRU_RS_PERF_CNT_EN
  logic [31:0]             perf_full_cyc_o, perf_stall_cyc_o;
`endif

  bru_rs #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_pkt_i(disp_pkt_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_pkt_o(issue_pkt_o),
    .count_o(count_o)
`ifdef BRU_RS_PERF_CNT_EN
    , .perf_full_cyc_o(perf_full_cyc_o), .perf_stall_cyc_o(perf_stall_cyc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    issue_pkt_t pkt;
    bit         r1;
    bit         r2;
  } ment_t;

  ment_t mq[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    m_full   = 0;
  int    m_stall  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  function automatic bit m_hit(input logic [PREG_W-1:0] tag);
    for (int k = 0; k < WB; k++)
      if (cdb_valid_i[k] && (cdb_tag_i[k*PREG_W +: PREG_W] == tag)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic issue_pkt_t mk(input int rob, input int t1, input int t2);
    issue_pkt_t p;
    p.op      = 4'($urandom);
    p.pc      = $urandom;
    p.imm     = $urandom;
    p.rob_tag = ROB_W'(rob);
    p.rs1_tag = PREG_W'(t1);
    p.rs2_tag = PREG_W'(t2);
    return p;
  endfunction

  task automatic check_outputs();
    int s;
    logic [127:0] exp_pkt;
    s = m_sel();
    exp_pkt = '0;
    if (s >= 0) exp_pkt = 128'(mq[s].pkt);
    chk("count", 128'(count_o), 128'(mq.size()));
    chk("disp_ready", 128'(disp_ready_o), 128'(mq.size() != DEPTH));
    chk("issue_valid", 128'(issue_valid_o), 128'(s >= 0));
    chk("issue_pkt", 128'(issue_pkt_o), exp_pkt);
`ifdef BRU_RS_PERF_CNT_EN
    chk("perf_full", 128'(perf_full_cyc_o), 128'(m_full));
    chk("perf_stall", 128'(perf_stall_cyc_o), 128'(m_stall));
`endif
  endtask

  task automatic model_step();
    int s;
    bit full;
    ment_t e;
    s    = m_sel();
    full = (mq.size() == DEPTH);
    if (full) m_full++;
    if (mq.size() != 0 && s < 0) m_stall++;
    if (flush_i) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        if (m_hit(mq[i].pkt.rs1_tag)) mq[i].r1 = 1'b1;
        if (m_hit(mq[i].pkt.rs2_tag)) mq[i].r2 = 1'b1;
      end
      if (s >= 0 && issue_ready_i) mq.delete(s);
      if (disp_valid_i && !full) begin
        e.pkt = disp_pkt_i;
        e.r1  = disp_rs1_rdy_i | m_hit(disp_pkt_i.rs1_tag);
        e.r2  = disp_rs2_rdy_i | m_hit(disp_pkt_i.rs2_tag);
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i        = 1'b0;
    disp_valid_i   = 1'b0;
    disp_pkt_i     = '0;
    disp_rs1_rdy_i = 1'b0;
    disp_rs2_rdy_i = 1'b0;
    cdb_valid_i    = '0;
    cdb_tag_i      = '0;
    issue_ready_i  = 1'b0;
  endtask

  task automatic disp(input issue_pkt_t p, input bit r1, input bit r2);
    disp_valid_i   = 1'b1;
    disp_pkt_i     = p;
    disp_rs1_rdy_i = r1;
    disp_rs2_rdy_i = r2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_disp_ready"}, 128'(disp_ready_o), 128'(1));
    chk({tag, "_issue_valid"}, 128'(issue_valid_o), 128'(0));
    chk({tag, "_count"}, 128'(count_o), 128'(0));
    chk({tag, "_issue_pkt"}, 128'(issue_pkt_o), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    chk_reset_outs("reset");
`ifdef BRU_RS_PERF_CNT_EN
    chk("reset_perf_full", 128'(perf_full_cyc_o), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // A: ready at dispatch, issues the following cycle
    disp(mk(3, 1, 2), 1'b1, 1'b1); issue_ready_i = 1'b1;
    tick();
    chk("a_valid", 128'(issue_valid_o), 128'(1));
    chk("a_rob", 128'(issue_pkt_o.rob_tag), 128'(3));
    chk("a_count1", 128'(count_o), 128'(1));
    idle(); issue_ready_i = 1'b1;
    tick();
    chk("a_count0", 128'(count_o), 128'(0));

    // B waits on tag 9, C is ready and younger; C issues first
    idle(); disp(mk(4, 9, 0), 1'b0, 1'b1);
    tick();
    idle(); disp(mk(5, 1, 2), 1'b1, 1'b1);
    tick();
    idle(); issue_ready_i = 1'b1; cdb_valid_i = 2'b10; cdb_tag_i[PREG_W +: PREG_W] = 6'd9;
    chk("c_first", 128'(issue_pkt_o.rob_tag), 128'(5));
    tick();
    chk("b_woken", 128'(issue_valid_o), 128'(1));
    chk("b_rob", 128'(issue_pkt_o.rob_tag), 128'(4));
    idle(); issue_ready_i = 1'b1;
    tick();

    // Fill with four waiters on tag 20; a fifth dispatch is held
    for (int k = 0; k < DEPTH; k++) begin
      idle(); disp(mk(k, 20, 30), 1'b0, 1'b1);
      tick();
    end
    chk("full_ready", 128'(disp_ready_o), 128'(0));
    chk("full_count", 128'(count_o), 128'(4));
    idle(); disp(mk(7, 1, 2), 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    chk("held_count", 128'(count_o), 128'(4));
`ifdef BRU_RS_PERF_CNT_EN
    chk("perf_full10", 128'(perf_full_cyc_o), 128'(10));
    chk("perf_stall_ge10", 128'(perf_stall_cyc_o >= 32'd10), 128'(1));
`endif
    idle(); issue_ready_i = 1'b1; cdb_valid_i = 2'b01; cdb_tag_i[0 +: PREG_W] = 6'd20;
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      idle(); issue_ready_i = 1'b1;
      chk("order_valid", 128'(issue_valid_o), 128'(1));
      chk("order_rob", 128'(issue_pkt_o.rob_tag), 128'(k));
      tick();
    end
    chk("drained", 128'(count_o), 128'(0));

    // D: rs2 woken by same-cycle CDB bypass
    idle(); disp(mk(8, 1, 17), 1'b1, 1'b0); cdb_valid_i = 2'b01; cdb_tag_i[0 +: PREG_W] = 6'd17;
    tick();
    chk("bypass_valid", 128'(issue_valid_o), 128'(1));
    chk("bypass_rob", 128'(issue_pkt_o.rob_tag), 128'(8));
    idle(); issue_ready_i = 1'b1;
    tick();

    // Flush with dispatch and issue requested in the same cycle
    for (int k = 0; k < 3; k++) begin
      idle(); disp(mk(10 + k, 1, 2), 1'b1, 1'b1);
      tick();
    end
    chk("pre_flush_count", 128'(count_o), 128'(3));
    idle(); flush_i = 1'b1; issue_ready_i = 1'b1; disp(mk(13, 1, 2), 1'b1, 1'b1);
    chk("flush_cycle_valid", 128'(issue_valid_o), 128'(1));
    tick();
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_valid", 128'(issue_valid_o), 128'(0));
    chk("flush_ready", 128'(disp_ready_o), 128'(1));
    idle();
    tick();

    // Asynchronous reset in the middle of a cycle
    for (int k = 0; k < 2; k++) begin
      idle(); disp(mk(14 + k, 1, 2), 1'b1, 1'b1);
      tick();
    end
    idle();
    chk("pre_arst_count", 128'(count_o), 128'(2));
    #2 rst = 1'b1;
    #1 chk_reset_outs("arst");
    mq.delete(); m_full = 0; m_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      idle();
      flush_i       = ($urandom_range(39) == 0);
      issue_ready_i = ($urandom_range(9) < 6);
      if ($urandom_range(1) == 1)
        disp(mk(int'($urandom_range(31)), int'($urandom_range(7)), int'($urandom_range(7))),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int k = 0; k < WB; k++) begin
        cdb_valid_i[k] = ($urandom_range(9) < 3);
        cdb_tag_i[k*PREG_W +: PREG_W] = PREG_W'($urandom_range(7));
      end
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bru_rs.md
Name: bru_rs

Overview:
- Reservation station for the branch/jump unit. Sits between rename/dispatch and the branch functional unit.
- Buffers up to DEPTH branch/jump issue packets and tracks source-operand readiness by snooping CDB writeback tags.
- Each cycle, issues the oldest fully-ready entry to the branch FU over a valid/ready handshake.
- Flushed wholesale on a redirect.

Parameters:
- DEPTH, 4, number of RS entries; power of two, at least 2.
- WB_PORTS, 2, number of CDB writeback ports snooped for wakeup.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  discard all entries.
- disp_valid_i  input  1  dispatch offers a packet.
- disp_ready_o  output  1  RS can accept a packet.
- disp_pkt_i  input  issue_pkt_t  dispatched packet (rs1_tag, rs2_tag, rob_tag, ...).
- disp_rs1_rdy_i  input  1  rs1 value already in PRF, or rs1 unused.
- disp_rs2_rdy_i  input  1  rs2 value already in PRF, or rs2 unused.
- cdb_valid_i  input  WB_PORTS  per-port writeback valid.
- cdb_tag_i  input  WB_PORTS*PREG_W  per-port writeback tag; port k at bits [k*PREG_W +: PREG_W].
- issue_valid_o  output  1  a ready entry is presented.
- issue_ready_i  input  1  branch FU accepts.
- issue_pkt_o  output  issue_pkt_t  packet of the selected entry.
- count_o  output  CNT_W  number of valid entries.

Behaviour:
- Per-entry state: valid, pkt, rs1_rdy, rs2_rdy. Age matrix: DEPTH x DEPTH bits, where older[i][j]=1 means entry i is older than entry j.
- Reset (async, rst=1): all valid=0; age matrix=0.
  - Outputs during reset: disp_ready_o=1, issue_valid_o=0, count_o=0, issue_pkt_o='0.
- Allocation:
  - disp_ready_o = (count_o != DEPTH). Computed from registered state only; a same-cycle issue does not free a slot for that cycle's dispatch.
  - On disp_valid_i && disp_ready_o && !flush_i, write the lowest-index free entry.
  - The new entry's row is cleared, and its column is set for every currently valid entry, which makes the new entry the youngest.
- Wakeup:
  - For each valid entry and each port k with cdb_valid_i[k] and a tag equal to rs1_tag (resp. rs2_tag), set rs1_rdy (resp. rs2_rdy) at the clock edge.
  - Dispatch-cycle bypass: if the dispatching packet's source tag matches any valid CDB tag in the same cycle, the entry is written with that ready bit set, regardless of disp_rsX_rdy_i.
- Select:
  - Ready(i) = valid && rs1_rdy && rs2_rdy, using registered bits only. A wakeup or dispatch therefore becomes issuable one cycle after the event; there is no same-cycle wake-to-issue.
  - Selected entry = the ready entry for which no other ready entry is older.
  - issue_valid_o = any ready entry. issue_pkt_o = selected entry's pkt, purely combinational from state. issue_pkt_o holds '0 when issue_valid_o=0.
- Issue:
  - On issue_valid_o && issue_ready_i && !flush_i, clear the selected entry's valid bit and its age-matrix row and column.
  - When issue_ready_i=0, the selection stays stable unless an older entry becomes ready.
- Simultaneous events: issue and dispatch in the same cycle are both performed, so count is unchanged. The freed slot becomes reusable next cycle.
- Flush: flush_i=1 clears all valid bits and the age matrix at the edge, and drops any dispatch or issue in that cycle.
  - issue_valid_o is still driven combinationally during the flush cycle; the FU must gate it with flush_i. The branch FU already ignores issue during flush.
- count_o is a registered popcount, updated by +1 on dispatch, -1 on issue, and reset to 0 by flush.
- Reset asserted mid-operation discards all state immediately, without waiting for a clock edge.

Optional Feature:
- Macro BRU_RS_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_full_cyc_o[31:0] and perf_stall_cyc_o[31:0].
  - perf_full_cyc_o counts cycles with count_o==DEPTH.
  - perf_stall_cyc_o counts cycles with count_o!=0 && !issue_valid_o.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0 on rst, and are not cleared by flush.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then dispatch pkt A with rob_tag=3 and both rdy=1 -> the cycle after dispatch: issue_valid_o=1, issue_pkt_o.rob_tag=3. With issue_ready_i=1, count_o goes 0->1->0.
- Dispatch B (rs1_tag=9, rs1_rdy=0), then C (ready). Then drive cdb_valid_i[1]=1, cdb_tag=9 -> C issues first. B becomes issuable the cycle after the CDB pulse.
- Fill 4 entries, none ready -> disp_ready_o=0 and a 5th dispatch is held. Wake all four in one cycle -> they issue in dispatch order 0,1,2,3 while issue_ready_i stays high.
- Dispatch D with rs2_tag=17, disp_rs2_rdy_i=0, while cdb_tag port0=17 is valid in the same cycle -> D is issuable next cycle (bypass).
- With 3 valid entries, assert flush_i together with disp_valid_i and issue_ready_i -> next cycle count_o=0, issue_valid_o=0, disp_ready_o=1, no issue handshake counted.
- With BRU_RS_PERF_CNT_EN: hold the RS full with nothing ready for 10 cycles -> perf_full_cyc_o=10, perf_stall_cyc_o>=10.
